// File: rtl/mio_access_unit.sv
// mio_access_unit: single-outstanding MIO bus access sequencer (IDLE -> ACCESS -> RESP).
// Define MIO_TIMEOUT_EN to enable the wait-state timeout counter and rsp_err reporting.
module mio_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                CPU_MIO,
    output logic                mem_w,
    output logic [ADDR_W-1:0]   Addr_out,
    output logic [DATA_W-1:0]   Data_out,
    output logic [DATA_W/8-1:0] BE_out,
    input  logic                MIO_ready,
    input  logic [DATA_W-1:0]   Data_in,
    output logic                busy,
    output logic [1:0]          state
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BE_W-1:0]     be_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                accept;
    logic                complete;
    logic                expired;

`ifdef MIO_TIMEOUT_EN
    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    assign expired = (cnt_q == CNT_MAX);

    // Counter saturates at TIMEOUT so it can never wrap back below the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (state_q == ACCESS && !MIO_ready && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Completion without MIO_ready can only be a timeout; ready wins a tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (complete) begin
            err_q <= ~MIO_ready;
        end
    end

    assign rsp_err = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign expired        = 1'b0;
    assign rsp_err        = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (MIO_ready || expired) begin
                    complete = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    // Data_in is sampled only on the completing edge; writes and timeouts return 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (complete) begin
            rdata_q <= (we_q || !MIO_ready) ? '0 : Data_in;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign CPU_MIO   = (state_q == ACCESS);
    assign mem_w     = (state_q == ACCESS) && we_q;
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign state     = state_q;
    assign Addr_out  = addr_q;
    assign Data_out  = wdata_q;
    assign BE_out    = be_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mio_access_unit.sv
// Self-checking bench for mio_access_unit: transaction-level reference model, random traffic,
// directed corner cases, and a 64-bit/16-bit width variant.
module tb_mio_access_unit;

    localparam int TMO = 4;
`ifdef MIO_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        CPU_MIO, mem_w;
    logic [31:0] Addr_out, Data_out;
    logic [3:0]  BE_out;
    logic        MIO_ready;
    logic [31:0] Data_in;
    logic        busy;
    logic [1:0]  state;

    logic        w_req_valid, w_req_ready, w_req_we;
    logic [15:0] w_req_addr;
    logic [63:0] w_req_wdata;
    logic [7:0]  w_req_be;
    logic        w_rsp_valid, w_rsp_err;
    logic [63:0] w_rsp_rdata;
    logic        w_CPU_MIO, w_mem_w;
    logic [15:0] w_Addr_out;
    logic [63:0] w_Data_out;
    logic [7:0]  w_BE_out;
    logic        w_MIO_ready;
    logic [63:0] w_Data_in;
    logic        w_busy;
    logic [1:0]  w_state;

    int n_checks = 0;
    int n_errors = 0;

    mio_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .CPU_MIO(CPU_MIO), .mem_w(mem_w), .Addr_out(Addr_out), .Data_out(Data_out),
        .BE_out(BE_out), .MIO_ready(MIO_ready), .Data_in(Data_in),
        .busy(busy), .state(state)
    );

    mio_access_unit #(.ADDR_W(16), .DATA_W(64), .TIMEOUT(TMO)) u_wide (
        .clk(clk), .reset(reset),
        .req_valid(w_req_valid), .req_ready(w_req_ready), .req_we(w_req_we),
        .req_addr(w_req_addr), .req_wdata(w_req_wdata), .req_be(w_req_be),
        .rsp_valid(w_rsp_valid), .rsp_rdata(w_rsp_rdata), .rsp_err(w_rsp_err),
        .CPU_MIO(w_CPU_MIO), .mem_w(w_mem_w), .Addr_out(w_Addr_out), .Data_out(w_Data_out),
        .BE_out(w_BE_out), .MIO_ready(w_MIO_ready), .Data_in(w_Data_in),
        .busy(w_busy), .state(w_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Status bundle {req_ready, busy, CPU_MIO, mem_w, rsp_valid, state}
    function automatic logic [6:0] st_idle();
        return 7'b1_0_0_0_0_00;
    endfunction
    function automatic logic [6:0] st_access(input logic we);
        return {1'b0, 1'b1, 1'b1, we, 1'b0, 2'd1};
    endfunction
    function automatic logic [6:0] st_resp();
        return 7'b0_1_0_0_1_10;
    endfunction

    function automatic logic [6:0] status();
        return {req_ready, busy, CPU_MIO, mem_w, rsp_valid, state};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction from an idle unit; waits = MIO_ready-low cycles before ready.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input int waits, input logic [31:0] bus_data);
        bit          to;
        int          acc_cycles;
        logic [31:0] exp_rdata;
        to         = TO_EN && (waits > TMO);
        acc_cycles = to ? TMO + 1 : waits + 1;
        exp_rdata  = (we || to) ? 32'h0 : bus_data;

        check("idle_status", status(), st_idle());
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        MIO_ready = 1'($urandom);
        Data_in   = $urandom;
        tick();
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);

        for (int i = 0; i < acc_cycles; i++) begin
            check("access_status", status(), st_access(we));
            check("access_addr", Addr_out, addr);
            check("access_data", Data_out, wdata);
            check("access_be", BE_out, be);
            MIO_ready = (!to && i == waits);
            Data_in   = MIO_ready ? bus_data : $urandom;
            tick();
        end
        MIO_ready = 1'($urandom);
        Data_in   = $urandom;
        check("resp_status", status(), st_resp());
        check("resp_rdata", rsp_rdata, exp_rdata);
        check("resp_err", rsp_err, to);
        tick();
        check("post_status", status(), st_idle());
        check("hold_rdata", rsp_rdata, exp_rdata);
        check("hold_err", rsp_err, to);
        check("hold_addr", Addr_out, addr);
    endtask

    initial begin
        logic [31:0] da, db;
        reset       = 1'b0;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_be      = '0;
        MIO_ready   = 1'b0;
        Data_in     = '0;
        w_req_valid = 1'b0;
        w_req_we    = 1'b0;
        w_req_addr  = '0;
        w_req_wdata = '0;
        w_req_be    = '0;
        w_MIO_ready = 1'b0;
        w_Data_in   = '0;
        #12;
        check("rst_outputs", {CPU_MIO, mem_w, rsp_valid, rsp_err, busy, state}, 0);
        check("rst_bus", {Addr_out, Data_out, BE_out}, 0);
        check("rst_rdata", rsp_rdata, 0);
        #10;
        reset = 1'b1;
        tick();

        // Zero-wait read, then a 3-wait-state partial write
        run_txn(1'b0, 32'h0000_0040, 32'h0, 4'hF, 0, 32'hDEAD_BEEF);
        run_txn(1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0011, 3, 32'hCAFE_F00D);
        // Zero byte enables still run a bus cycle
        run_txn(1'b1, 32'h0000_0200, 32'hA5A5_5A5A, 4'b0000, 1, 32'h0);
        // Ready exactly at count TIMEOUT wins, then a real timeout
        run_txn(1'b0, 32'h0000_0300, 32'h0, 4'hF, TMO, 32'h1357_9BDF);
        run_txn(1'b0, 32'h0000_0304, 32'h0, 4'hF, 9, 32'h2468_ACE0);
        run_txn(1'b1, 32'h0000_0308, 32'h7777_8888, 4'hC, 7, 32'h0);

        for (int n = 0; n < 40; n++) begin
            run_txn(1'($urandom), $urandom, $urandom, 4'($urandom),
                    int'($urandom_range(0, 7)), $urandom);
        end

        // Back-to-back reads with req_valid held high
        da        = 32'h1111_2222;
        db        = 32'h3333_4444;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_1000;
        req_be    = 4'hF;
        MIO_ready = 1'b1;
        Data_in   = da;
        tick();
        check("b2b_acc_a", status(), st_access(1'b0));
        check("b2b_addr_a", Addr_out, 32'h0000_1000);
        req_addr = 32'h0000_2000;
        tick();
        check("b2b_resp_a", status(), st_resp());
        check("b2b_rdata_a", rsp_rdata, da);
        Data_in = db;
        tick();
        check("b2b_idle", status(), st_idle());
        tick();
        req_valid = 1'b0;
        check("b2b_acc_b", status(), st_access(1'b0));
        check("b2b_addr_b", Addr_out, 32'h0000_2000);
        tick();
        check("b2b_resp_b", status(), st_resp());
        check("b2b_rdata_b", rsp_rdata, db);
        tick();
        check("b2b_done", status(), st_idle());

        // Reset in the middle of a wait-stated write
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0000_0500;
        req_wdata = 32'h0BAD_F00D;
        MIO_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        check("mid_access", status(), st_access(1'b1));
        #2;
        reset = 1'b0;
        #1;
        check("rst_drop", {CPU_MIO, mem_w, rsp_valid}, 0);
        check("rst_addr", Addr_out, 0);
        MIO_ready = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("after_rst", status(), st_idle());
        end
        run_txn(1'b0, 32'h0000_0600, 32'h0, 4'hF, 2, 32'hFEED_FACE);

        // 64-bit data / 16-bit address variant
        w_req_valid = 1'b1;
        w_req_we    = 1'b0;
        w_req_addr  = 16'h1234;
        w_req_be    = 8'hA5;
        w_MIO_ready = 1'b1;
        w_Data_in   = 64'h0123_4567_89AB_CDEF;
        tick();
        w_req_valid = 1'b0;
        check("wide_access", {w_CPU_MIO, w_mem_w, w_state}, {1'b1, 1'b0, 2'd1});
        check("wide_addr", w_Addr_out, 16'h1234);
        check("wide_be", w_BE_out, 8'hA5);
        tick();
        check("wide_resp", {w_rsp_valid, w_rsp_err}, 2'b10);
        check("wide_rdata", w_rsp_rdata, 64'h0123_4567_89AB_CDEF);
        tick();
        check("wide_idle", {w_req_ready, w_busy}, 2'b10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
